// File: rtl/tiny_acc_sequencer.sv
// Accumulator micro-sequencer that drives the GPIO register write port from a small program RAM.
// Latency: 2 cycles per instruction (FETCH+EXEC), WAIT n adds n; gpio_wen pulses the cycle after OUT.
// No backpressure: the GPIO port always accepts; run=0 stops at the next instruction boundary.
module tiny_acc_sequencer #(
    parameter int PROG_AW = 4,
    parameter int WAIT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [11:0]        prog_data,
    input  logic [7:0]         gpio_rdata,
    output logic               gpio_wen,
    output logic [7:0]         gpio_wdata,
    output logic [PROG_AW-1:0] pc,
    output logic               halted,
    output logic               zero
);

    localparam int DEPTH = 1 << PROG_AW;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_IN   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_WAIT = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    state_t             state;
    logic [11:0]        prog_ram [DEPTH];
    logic [11:0]        ir;
    logic [7:0]         acc;
    logic               carry;
    logic [WAIT_W-1:0]  wait_cnt;

    logic [3:0]         op;
    logic [7:0]         imm;
    logic [8:0]         sum9;
    logic [7:0]         alu_acc;
    logic               alu_carry;
    logic               upd_zero;
    logic               upd_carry;
    logic               jump_taken;
    logic [PROG_AW-1:0] pc_next;
    logic               prog_wr_ok;

    assign op  = ir[11:8];
    assign imm = ir[7:0];

    // The RAM is only writable while nothing is executing out of it.
    assign prog_wr_ok = prog_we && ((state == S_IDLE) || (state == S_HALT));

    always_ff @(posedge clk) begin
        if (prog_wr_ok) begin
            prog_ram[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        sum9      = '0;
        alu_acc   = acc;
        alu_carry = carry;
        upd_zero  = 1'b0;
        upd_carry = 1'b0;
        case (op)
            OP_LDI: begin alu_acc = imm;       upd_zero = 1'b1; end
            OP_ADD: begin
                sum9      = {1'b0, acc} + {1'b0, imm};
                alu_acc   = sum9[7:0];
                alu_carry = sum9[8];
                upd_zero  = 1'b1;
                upd_carry = 1'b1;
            end
            // Bit 8 of the 9-bit difference is set exactly when acc < imm (borrow).
            OP_SUB: begin
                sum9      = {1'b0, acc} - {1'b0, imm};
                alu_acc   = sum9[7:0];
                alu_carry = sum9[8];
                upd_zero  = 1'b1;
                upd_carry = 1'b1;
            end
            OP_AND: begin alu_acc = acc & imm; upd_zero = 1'b1; end
            OP_OR:  begin alu_acc = acc | imm; upd_zero = 1'b1; end
            OP_XOR: begin alu_acc = acc ^ imm; upd_zero = 1'b1; end
            OP_SHL: begin
                alu_acc   = {acc[6:0], 1'b0};
                alu_carry = acc[7];
                upd_zero  = 1'b1;
                upd_carry = 1'b1;
            end
            OP_SHR: begin
                alu_acc   = {1'b0, acc[7:1]};
                alu_carry = acc[0];
                upd_zero  = 1'b1;
                upd_carry = 1'b1;
            end
            OP_IN:  begin alu_acc = gpio_rdata; upd_zero = 1'b1; end
            default: ;
        endcase
    end

    assign jump_taken = (op == OP_JMP) || ((op == OP_JZ) && zero) || ((op == OP_JC) && carry);
    assign pc_next    = jump_taken ? imm[PROG_AW-1:0] : pc + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            acc        <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            gpio_wen   <= 1'b0;
            gpio_wdata <= '0;
            halted     <= 1'b0;
            ir         <= '0;
            wait_cnt   <= '0;
        end else begin
            gpio_wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else begin
                        ir    <= prog_ram[pc];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc <= alu_acc;
                    if (upd_zero)  zero  <= (alu_acc == 8'h00);
                    if (upd_carry) carry <= alu_carry;
                    if (op == OP_OUT) begin
                        gpio_wen   <= 1'b1;
                        gpio_wdata <= acc;
                    end
                    if (op == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= pc_next;
                        if ((op == OP_WAIT) && (imm != 8'h00)) begin
                            wait_cnt <= WAIT_W'(imm);
                            state    <= S_WAIT;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                // Count reaching 1 ends the wait, so WAIT n spends exactly n cycles here.
                S_WAIT: begin
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state  <= S_IDLE;
                        pc     <= '0;
                        halted <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
